// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
// State encoding and parameter defaults live here.
package debounce_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_WAIT,
    S_HIGH,
    S_FALL_WAIT
  } debounce_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous input.
// The last flop is the synchronized output.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] ff;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a bouncy input.
// Edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("input_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync;
  debounce_state_t state_q;
  debounce_state_t state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            level_q;
  logic            level_d;
  logic            busy_q;
  logic            busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (raw_i),
    .q_o     (sync)
  );

  // Next state: qualify a candidate level for DEBOUNCE_CYCLES+1 samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Moore outputs decoded from the next state, registered with it.
  always_comb begin
    level_d = (state_d == S_HIGH) || (state_d == S_FALL_WAIT);
    busy_d  = (state_d == S_RISE_WAIT) || (state_d == S_FALL_WAIT);
  end

  // State, counter and level/busy registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulse in the first cycle the registered level shows its new value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer.
// Reference: sync = raw delayed; level flips after DC+1 mismatching samples.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int SS = SYNC_STAGES_DEF;
  localparam int DC = DEBOUNCE_CYCLES_DEF;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw = 1'b0;
  logic level, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  logic rq[$];
  logic m_level, m_rise, m_fall, m_busy;
  int   run;

  input_debouncer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .raw_i   (raw),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  function automatic void mreset();
    rq.delete();
    for (int i = 0; i < SS; i++) rq.push_back(1'b0);
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_busy  = 1'b0;
    run     = 0;
  endfunction

  function automatic void medge(logic r);
    logic s;
    if (reset) begin
      mreset();
      return;
    end
    rq.push_back(r);
    s = rq.pop_front();
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_level) begin
      run++;
      if (run == DC + 1) begin
        m_level = s;
        m_rise  = s;
        m_fall  = !s;
        run     = 0;
      end
    end else begin
      run = 0;
    end
    m_busy = (run > 0);
  endfunction

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_level", level, m_level);
    chk("model_busy", busy, m_busy);
    chk("model_rise", rise, m_rise & EDGE);
    chk("model_fall", fall, m_fall & EDGE);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, level, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rise"}, rise, 1'b0);
    chk({tag, "_fall"}, fall, 1'b0);
  endtask

  task automatic tick(input logic r);
    raw = r;
    @(posedge clk);
    medge(r);
    #1;
    chk_model();
  endtask

  initial begin
    int first_idx;
    int pulses;
    bit saw_busy;
    logic b;
    int len;

    mreset();
    #2;
    chk_zero("reset_hold");
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    repeat (10) tick(1'b0);

    // clean rise
    for (int k = 0; k < 8; k++) begin
      tick(1'b1);
      chk("r028_level", level, k >= 6);
      chk("r028_busy", busy, k >= 2 && k <= 5);
      chk("r028_rise", rise, EDGE && k == 6);
    end

    // clean fall
    for (int k = 0; k < 8; k++) begin
      tick(1'b0);
      chk("r031_level", level, k < 6);
      chk("r031_busy", busy, k >= 2 && k <= 5);
      chk("r031_fall", fall, EDGE && k == 6);
    end

    // glitch
    saw_busy = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick(k < 3);
      if (busy) saw_busy = 1'b1;
      chk("r029_level", level, 1'b0);
      chk("r029_rise", rise, 1'b0);
      chk("r029_fall", fall, 1'b0);
    end
    chk("r029_saw_busy", saw_busy, 1'b1);
    chk("r029_busy_end", busy, 1'b0);

    // bounce
    first_idx = -1;
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      b = (k < 4) ? ((k % 2) == 0) : 1'b1;
      tick(b);
      if (level && first_idx < 0) first_idx = k;
      if (rise) pulses++;
    end
    checks++;
    assert (first_idx === 10) else begin
      errors++;
      $error("FAIL r030_latency observed=%0d expected=%0d",
             first_idx, 10);
    end
    checks++;
    assert (pulses === (EDGE ? 1 : 0)) else begin
      errors++;
      $error("FAIL r030_pulses observed=%0d expected=%0d",
             pulses, EDGE ? 1 : 0);
    end

    // reset mid-wait with raw held high
    repeat (8) tick(1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1);
    chk("r032_busy_pre", busy, 1'b1);
    reset = 1'b1;
    mreset();
    #1;
    chk_zero("r032_async");
    tick(1'b1);
    tick(1'b1);
    chk_zero("r032_held");
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1);
      chk("r032_level", level, k >= 6);
      chk("r032_rise", rise, EDGE && k == 6);
    end

    // randomized runs with occasional async reset
    b = 1'b0;
    for (int n = 0; n < 600; n++) begin
      b = ~b;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) tick(b);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        mreset();
        #1;
        chk_zero("rand_reset");
        tick(b);
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on raw_i; legal values are >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: stability window in cycles; legal values are >= 1.
REQ-003 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  reset; asynchronous, active-high.
REQ-005 raw_i  input  1  asynchronous, bouncy input such as a button or switch.
REQ-006 level_o  output  1  debounced level; this SHALL drive the downstream FSM's in_i.
REQ-007 rise_o  output  1  one-cycle pulse on each debounced 0->1 transition.
REQ-008 fall_o  output  1  one-cycle pulse on each debounced 1->0 transition.
REQ-009 busy_o  output  1  high while a candidate transition is being qualified.

Function
REQ-010 raw_i SHALL pass through a SYNC_STAGES-flop chain; the last flop is the synchronized value "sync".
REQ-011 The FSM SHALL have four states: S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT.
REQ-012 S_LOW: if sync=1, go to S_RISE_WAIT and clear cnt; otherwise stay.
REQ-013 S_RISE_WAIT behaviour:
- if sync=0, return to S_LOW and clear cnt;
- else if cnt==DEBOUNCE_CYCLES-1, go to S_HIGH;
- else increment cnt.
REQ-014 S_HIGH and S_FALL_WAIT SHALL mirror REQ-012 and REQ-013 with sync polarity inverted; S_FALL_WAIT commits to S_LOW.
REQ-015 Outputs SHALL be Moore and registered from state:
- level_o=1 in S_HIGH and S_FALL_WAIT;
- busy_o=1 in either WAIT state.
REQ-016 Latency: level_o SHALL change exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after raw_i settles, provided sync stays stable for DEBOUNCE_CYCLES+1 consecutive samples.
REQ-017 Any sync reversal during a WAIT state SHALL abort the candidate: no level_o change and no pulse.
REQ-018 rise_o and fall_o SHALL be high in exactly the first cycle that level_o shows its new value.
REQ-019 cnt width SHALL be max(1, $clog2(DEBOUNCE_CYCLES)); cnt SHALL never wrap.
REQ-020 With DEBOUNCE_CYCLES=1, a WAIT state SHALL commit on the first sample that still matches.
REQ-021 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-022 While reset_i is high:
- the synchronizer, cnt and all outputs SHALL be 0;
- the state SHALL be S_LOW.
REQ-023 Reset mid-qualification SHALL discard the candidate.
REQ-024 If raw_i is held high through reset release, it SHALL be re-qualified normally: level_o rises SYNC_STAGES+DEBOUNCE_CYCLES edges after release, with rise_o pulsed.

Configuration
REQ-025 Macro DEBOUNCE_EDGE_EN controls the edge outputs:
- defined: rise_o and fall_o behave per REQ-018;
- undefined: both are tied to 0, no edge logic is generated, and level_o and busy_o are unchanged.

Structure
REQ-026 Package debounce_pkg SHALL hold the state enum type (debounce_state_t) and the parameter defaults.
REQ-027 Sub-module sync_chain (parameter STAGES; ports clk_i, reset_i, d_i, q_o) SHALL implement REQ-010.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-028 Clean rise: raw_i 0->1 before edge e0 and held.
- Response: level_o=1 and rise_o=1 after e6; rise_o=0 after e7; busy_o=1 after e2..e5.
REQ-029 Glitch: raw_i high for 3 cycles, then low.
- Response: level_o, rise_o and fall_o stay 0; busy_o pulses, then returns to 0.
REQ-030 Bounce: raw_i toggles 1,0,1,0, then stays 1.
- Response: level_o rises exactly 6 edges after the final 0->1 edge; exactly one rise_o pulse.
REQ-031 Clean fall from S_HIGH: raw_i 1->0 and held.
- Response: level_o=0 and fall_o=1 after edge 6.
REQ-032 Reset mid-wait: assert reset_i while busy_o=1 with raw_i held 1.
- Response: all outputs are 0 immediately; level_o=1 six edges after release.
REQ-033 Scenario REQ-028 rebuilt without DEBOUNCE_EDGE_EN.
- Response: identical level_o and busy_o; rise_o and fall_o are constant 0.
